// File: rtl/skid_buffer.sv
// skid_buffer: two-entry registered valid/ready stage.
// Main register drives out_data; skid catches one word during a stall.
module skid_buffer #(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic [n-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [n-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [1:0]   count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t       state;
  logic [n-1:0] main_q;
  logic [n-1:0] skid_q;
  logic         push;
  logic         pop;

  // Handshake outputs come only from state, flush and reset.
  always_comb begin
    out_valid = (state != EMPTY);
    in_ready  = (state != FULL) && !flush && rst_n;
    count     = state;
    out_data  = main_q;
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
  end

  // Occupancy and storage update; reset beats flush beats normal flow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (push) begin
            main_q <= in_data;
            state  <= ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            main_q <= in_data;
          end else if (push) begin
            skid_q <= in_data;
            state  <= FULL;
          end else if (pop) begin
            state  <= EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            main_q <= skid_q;
            state  <= ONE;
          end
        end
        default: begin
          state <= EMPTY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_skid_buffer.sv
// tb_skid_buffer: directed vectors for skid_buffer.
// Inputs change 1ns after posedge; outputs checked there.
module tb_skid_buffer;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] count;

  int total;
  int passed;

  skid_buffer #(.n(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total     = 0;
    passed    = 0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'hAA;
    out_ready = 1'b0;

    // reset held two cycles with input offered
    #1;
    check("rst_ready0", 32'(in_ready), 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_data", 32'(out_data), 32'd0);
      check("rst_count", 32'(count), 32'd0);
      check("rst_ready", 32'(in_ready), 32'd0);
    end
    rst_n    = 1'b1;
    in_valid = 1'b0;
    #1;
    check("rel_ready", 32'(in_ready), 32'd1);

    // streaming 01..10 with out_ready high
    out_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      in_data  = 8'(i);
      in_valid = 1'b1;
      #1;
      check("str_ready", 32'(in_ready), 32'd1);
      tick();
      check("str_data", 32'(out_data), 32'(i));
      check("str_valid", 32'(out_valid), 32'd1);
      check("str_count", 32'(count), 32'd1);
    end
    in_valid = 1'b0;
    tick();
    check("str_drain", 32'(count), 32'd0);

    // stall: load 11, 22 with consumer stalled
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h11;
    tick();
    check("stl_one", 32'(out_data), 32'h11);
    in_data = 8'h22;
    tick();
    check("stl_full", 32'(count), 32'd2);

    // offer 33 for 3 cycles while full
    in_data = 8'h33;
    for (int i = 0; i < 3; i++) begin
      check("bp_ready", 32'(in_ready), 32'd0);
      check("bp_hold", 32'(out_data), 32'h11);
      check("bp_vld", 32'(out_valid), 32'd1);
      check("bp_count", 32'(count), 32'd2);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("pop1_ready", 32'(in_ready), 32'd0);
    tick();
    check("pop1_data", 32'(out_data), 32'h22);
    check("pop1_count", 32'(count), 32'd1);
    check("pop1_ready", 32'(in_ready), 32'd1);
    tick();
    check("bp33_data", 32'(out_data), 32'h33);
    check("bp33_count", 32'(count), 32'd1);
    in_valid = 1'b0;
    tick();
    check("bp33_once", 32'(out_valid), 32'd0);
    check("bp_empty", 32'(count), 32'd0);

    // flush in full state with 66 offered
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h44;
    tick();
    in_data = 8'h55;
    tick();
    check("fl_full", 32'(count), 32'd2);
    flush   = 1'b1;
    in_data = 8'h66;
    #1;
    check("fl_ready", 32'(in_ready), 32'd0);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("fl_count", 32'(count), 32'd0);
    check("fl_valid", 32'(out_valid), 32'd0);
    tick();
    check("fl_no66", 32'(out_valid), 32'd0);

    // reset mid-stream while a push is offered
    in_valid = 1'b1;
    in_data  = 8'h77;
    tick();
    check("mr_one", 32'(out_data), 32'h77);
    rst_n   = 1'b0;
    in_data = 8'h99;
    tick();
    check("mr_data", 32'(out_data), 32'd0);
    check("mr_count", 32'(count), 32'd0);
    check("mr_valid", 32'(out_valid), 32'd0);
    rst_n   = 1'b1;
    in_data = 8'h88;
    tick();
    in_valid = 1'b0;
    check("mr_88", 32'(out_data), 32'h88);
    check("mr_88v", 32'(out_valid), 32'd1);
    check("mr_88c", 32'(count), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
